// File: rtl/muldiv_hilo_unit.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
// Operands are captured at acceptance and processed over WIDTH cycles.
module muldiv_hilo_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Start,
   input  logic [4:0]       Op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             Busy,
   output logic             Done,
   output logic             DivZero,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo,
   output logic [WIDTH-1:0] Result
);

   localparam logic [4:0] OP_MULT  = 5'b00011;
   localparam logic [4:0] OP_MULTU = 5'b00100;
   localparam logic [4:0] OP_MUL   = 5'b10011;
   localparam logic [4:0] OP_MADD  = 5'b10100;
   localparam logic [4:0] OP_MSUB  = 5'b10101;
   localparam logic [4:0] OP_DIV   = 5'b11000;
   localparam logic [4:0] OP_DIVU  = 5'b11001;
   localparam logic [4:0] OP_MTHI  = 5'b11010;
   localparam logic [4:0] OP_MTLO  = 5'b11011;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FINISH = 2'd2} state_t;

   function automatic logic op_legal(input logic [4:0] op);
      case (op)
         OP_MULT, OP_MULTU, OP_MUL, OP_MADD, OP_MSUB,
         OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO: return 1'b1;
         default:                           return 1'b0;
      endcase
   endfunction

   function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic c);
      return c ? -v : v;
   endfunction

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [4:0]         op_q, op_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   logic [WIDTH-1:0]   hi_acc_q, hi_acc_d;
   logic [WIDTH-1:0]   lo_acc_q, lo_acc_d;
   logic               neg_res_q, neg_res_d;
   logic               neg_rem_q, neg_rem_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic [WIDTH-1:0]   res_q, res_d;
   logic               done_q, done_d;
   logic               dz_q, dz_d;

   logic               is_div;
   logic               signed_op;
   logic [WIDTH-1:0]   addend;
   logic [WIDTH:0]     add_sum;
   logic [WIDTH:0]     rem_shift;
   logic               rem_ge;
   logic [WIDTH-1:0]   rem_diff;
   logic [2*WIDTH-1:0] prod_s;
   logic [2*WIDTH-1:0] hilo;
   logic [2*WIDTH-1:0] hilo_new;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      opnd_d    = opnd_q;
      hi_acc_d  = hi_acc_q;
      lo_acc_d  = lo_acc_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      res_d     = res_q;
      done_d    = 1'b0;
      dz_d      = dz_q;
      hilo_new  = '0;

      is_div    = (op_q == OP_DIV) || (op_q == OP_DIVU);
      signed_op = (Op == OP_MULT) || (Op == OP_MUL) || (Op == OP_MADD) ||
                  (Op == OP_MSUB) || (Op == OP_DIV);

      // Multiply step: conditional add of the multiplicand, then shift the
      // {carry, hi_acc, lo_acc} chain right; lo_acc starts as the multiplier.
      addend    = lo_acc_q[0] ? opnd_q : '0;
      add_sum   = {1'b0, hi_acc_q} + {1'b0, addend};

      // Divide step: shift the next dividend bit into the partial remainder.
      rem_shift = {hi_acc_q, lo_acc_q[WIDTH-1]};
      rem_ge    = rem_shift >= {1'b0, opnd_q};
      rem_diff  = rem_shift[WIDTH-1:0] - opnd_q;

      prod_s    = neg_res_q ? -{hi_acc_q, lo_acc_q} : {hi_acc_q, lo_acc_q};
      hilo      = {hi_q, lo_q};

      unique case (state_q)
         S_IDLE: begin
            if (Start && op_legal(Op)) begin
               dz_d = 1'b0;
               op_d = Op;
               case (Op)
                  OP_MTHI: begin
                     hi_d   = A;
                     done_d = 1'b1;
                  end
                  OP_MTLO: begin
                     lo_d   = A;
                     done_d = 1'b1;
                  end
                  default: begin
                     if (((Op == OP_DIV) || (Op == OP_DIVU)) && (B == '0)) begin
                        dz_d   = 1'b1;
                        done_d = 1'b1;
                     end else begin
                        state_d   = S_RUN;
                        cnt_d     = '0;
                        hi_acc_d  = '0;
                        lo_acc_d  = cond_neg(A, signed_op && A[WIDTH-1]);
                        opnd_d    = cond_neg(B, signed_op && B[WIDTH-1]);
                        neg_res_d = signed_op && (A[WIDTH-1] ^ B[WIDTH-1]);
                        neg_rem_d = signed_op && A[WIDTH-1];
                     end
                  end
               endcase
            end
         end
         S_RUN: begin
            if (is_div) begin
               hi_acc_d = rem_ge ? rem_diff : rem_shift[WIDTH-1:0];
               lo_acc_d = {lo_acc_q[WIDTH-2:0], rem_ge};
            end else begin
               hi_acc_d = add_sum[WIDTH:1];
               lo_acc_d = {add_sum[0], lo_acc_q[WIDTH-1:1]};
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = S_FINISH;
            end
         end
         S_FINISH: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            case (op_q)
               OP_MULT, OP_MULTU: {hi_d, lo_d} = prod_s;
               OP_MADD: begin
                  hilo_new     = hilo + prod_s;
                  {hi_d, lo_d} = hilo_new;
               end
               OP_MSUB: begin
                  hilo_new     = hilo - prod_s;
                  {hi_d, lo_d} = hilo_new;
               end
               OP_MUL:  res_d = prod_s[WIDTH-1:0];
               default: begin
                  lo_d = cond_neg(lo_acc_q, neg_res_q);
                  hi_d = cond_neg(hi_acc_q, neg_rem_q);
               end
            endcase
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         op_q      <= '0;
         opnd_q    <= '0;
         hi_acc_q  <= '0;
         lo_acc_q  <= '0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         res_q     <= '0;
         done_q    <= 1'b0;
         dz_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         op_q      <= op_d;
         opnd_q    <= opnd_d;
         hi_acc_q  <= hi_acc_d;
         lo_acc_q  <= lo_acc_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         res_q     <= res_d;
         done_q    <= done_d;
         dz_q      <= dz_d;
      end
   end

   assign Busy    = (state_q != S_IDLE);
   assign Done    = done_q;
   assign DivZero = dz_q;
   assign Hi      = hi_q;
   assign Lo      = lo_q;
   assign Result  = res_q;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Randomized bench for muldiv_hilo_unit against a plain-arithmetic HI/LO model.
module tb_muldiv_hilo_unit;

   localparam int W = 32;

   localparam logic [4:0] OP_MULT  = 5'b00011;
   localparam logic [4:0] OP_MULTU = 5'b00100;
   localparam logic [4:0] OP_MUL   = 5'b10011;
   localparam logic [4:0] OP_MADD  = 5'b10100;
   localparam logic [4:0] OP_MSUB  = 5'b10101;
   localparam logic [4:0] OP_DIV   = 5'b11000;
   localparam logic [4:0] OP_DIVU  = 5'b11001;
   localparam logic [4:0] OP_MTHI  = 5'b11010;
   localparam logic [4:0] OP_MTLO  = 5'b11011;

   logic         Clk = 1'b0;
   logic         Rst;
   logic         Start;
   logic [4:0]   Op;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic         Busy;
   logic         Done;
   logic         DivZero;
   logic [W-1:0] Hi;
   logic [W-1:0] Lo;
   logic [W-1:0] Result;

   int n_chk = 0;
   int n_err = 0;

   logic [W-1:0] m_hi, m_lo, m_res;
   logic         m_dz;

   logic [4:0] legal_ops [9] = '{OP_MULT, OP_MULTU, OP_MUL, OP_MADD, OP_MSUB,
                                 OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO};

   muldiv_hilo_unit #(.WIDTH(W), .CNT_W(6)) dut (
      .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .A(A), .B(B),
      .Busy(Busy), .Done(Done), .DivZero(DivZero),
      .Hi(Hi), .Lo(Lo), .Result(Result)
   );

   always #5 Clk = ~Clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Architectural effect of one accepted op; returns cycles from acceptance to Done.
   task automatic model(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat);
      longint      sa, sb;
      logic [63:0] hl;
      sa   = longint'($signed(a));
      sb   = longint'($signed(b));
      hl   = {m_hi, m_lo};
      m_dz = 1'b0;
      lat  = W + 2;
      case (op)
         OP_MULT:  {m_hi, m_lo} = sa * sb;
         OP_MULTU: {m_hi, m_lo} = {32'b0, a} * {32'b0, b};
         OP_MUL:   m_res = 32'(sa * sb);
         OP_MADD:  {m_hi, m_lo} = hl + (sa * sb);
         OP_MSUB:  {m_hi, m_lo} = hl - (sa * sb);
         OP_DIV: begin
            if (b == 0) begin
               m_dz = 1'b1;
               lat  = 1;
            end else begin
               m_lo = 32'(sa / sb);
               m_hi = 32'(sa % sb);
            end
         end
         OP_DIVU: begin
            if (b == 0) begin
               m_dz = 1'b1;
               lat  = 1;
            end else begin
               m_lo = a / b;
               m_hi = a % b;
            end
         end
         OP_MTHI: begin
            m_hi = a;
            lat  = 1;
         end
         default: begin
            m_lo = a;
            lat  = 1;
         end
      endcase
   endtask

   // Called just after a falling edge; returns just after the falling edge of the Done cycle.
   task automatic run_op(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit pulse_busy);
      int lat;
      model(op, a, b, lat);
      Start = 1'b1;
      Op    = op;
      A     = a;
      B     = b;
      @(posedge Clk);
      #1;
      Start = 1'b0;
      Op    = 5'($urandom);
      A     = $urandom;
      B     = $urandom;
      for (int k = 1; k <= lat; k++) begin
         @(negedge Clk);
         chk("busy", 64'(Busy), 64'(lat > 1 && k < lat));
         chk("done", 64'(Done), 64'(k == lat));
         if (pulse_busy && lat > 1 && k == 5) begin
            Start = 1'b1;
            Op    = OP_MULTU;
            A     = $urandom;
            B     = $urandom;
         end
         if (k == 6) Start = 1'b0;
      end
      chk("hi", 64'(Hi), 64'(m_hi));
      chk("lo", 64'(Lo), 64'(m_lo));
      chk("result", 64'(Result), 64'(m_res));
      chk("divzero", 64'(DivZero), 64'(m_dz));
   endtask

   function automatic logic [W-1:0] rnd_opnd();
      case ($urandom_range(0, 6))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 15));
         4:       return 32'h0000_0001;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int n_done;
      logic [4:0] rop;
      Rst   = 1'b1;
      Start = 1'b0;
      Op    = '0;
      A     = '0;
      B     = '0;
      m_hi  = '0;
      m_lo  = '0;
      m_res = '0;
      m_dz  = 1'b0;
      repeat (2) @(negedge Clk);
      chk("rst_busy", 64'(Busy), 64'd0);
      chk("rst_done", 64'(Done), 64'd0);
      chk("rst_dz", 64'(DivZero), 64'd0);
      chk("rst_hi", 64'(Hi), 64'd0);
      chk("rst_lo", 64'(Lo), 64'd0);
      chk("rst_res", 64'(Result), 64'd0);
      Rst = 1'b0;
      @(negedge Clk);

      run_op(OP_MULT, 32'hFFFF_FFFD, 32'h0000_0007, 1'b0);
      chk("mult_hi_lit", 64'(Hi), 64'hFFFF_FFFF);
      chk("mult_lo_lit", 64'(Lo), 64'hFFFF_FFEB);
      run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      chk("multu_hi_lit", 64'(Hi), 64'hFFFF_FFFE);
      chk("multu_lo_lit", 64'(Lo), 64'h0000_0001);

      run_op(OP_MTLO, 32'h0000_000A, 32'h0, 1'b0);
      run_op(OP_MTHI, 32'h0000_0000, 32'h0, 1'b0);
      run_op(OP_MADD, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0);
      chk("madd_lo_lit", 64'(Lo), 64'h0000_0004);
      run_op(OP_MSUB, 32'h0000_0001, 32'h0000_0005, 1'b0);
      chk("msub_hilo_lit", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFFF);

      run_op(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
      chk("div_lit", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFFD);
      run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      chk("div_ovf_lit", {Hi, Lo}, 64'h0000_0000_8000_0000);
      run_op(OP_DIVU, 32'h0000_000A, 32'h0, 1'b0);
      chk("divz_lit", 64'(DivZero), 64'd1);

      run_op(OP_MUL, 32'h0001_0000, 32'h0001_0000, 1'b1);
      @(negedge Clk);
      chk("done_once", 64'(Done), 64'd0);
      chk("idle_after", 64'(Busy), 64'd0);

      // Illegal opcodes are ignored outright.
      Start = 1'b1;
      Op    = 5'b00000;
      A     = $urandom;
      B     = $urandom;
      @(negedge Clk);
      Op = 5'b11111;
      @(negedge Clk);
      Start = 1'b0;
      n_done = 0;
      for (int k = 0; k < 3; k++) begin
         if (Done || Busy) n_done++;
         @(negedge Clk);
      end
      chk("illegal_ignored", 64'(n_done), 64'd0);
      chk("illegal_hilo", {Hi, Lo}, {m_hi, m_lo});

      for (int i = 0; i < 40; i++) begin
         rop = legal_ops[$urandom_range(0, 8)];
         run_op(rop, rnd_opnd(), rnd_opnd(), 1'($urandom_range(0, 1)));
      end
      run_op(OP_MULT, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
      run_op(OP_MUL, 32'h0000_1234, 32'h0000_0011, 1'b0);

      // Asynchronous reset in the middle of a MULTU.
      Start = 1'b1;
      Op    = OP_MULTU;
      A     = $urandom;
      B     = $urandom;
      @(posedge Clk);
      #1;
      Start = 1'b0;
      repeat (10) @(negedge Clk);
      Rst = 1'b1;
      #1;
      chk("arst_busy", 64'(Busy), 64'd0);
      chk("arst_done", 64'(Done), 64'd0);
      chk("arst_dz", 64'(DivZero), 64'd0);
      chk("arst_hilo", {Hi, Lo}, 64'd0);
      chk("arst_res", 64'(Result), 64'd0);
      m_hi  = '0;
      m_lo  = '0;
      m_res = '0;
      m_dz  = 1'b0;
      @(negedge Clk);
      Rst = 1'b0;
      n_done = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge Clk);
         if (Done || Busy) n_done++;
      end
      chk("arst_no_done", 64'(n_done), 64'd0);
      run_op(OP_MULTU, 32'h0000_0123, 32'h0000_0456, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/muldiv_hilo_unit.md
Name: muldiv_hilo_unit

Overview:
- Iterative multi-cycle multiply/divide unit with architectural HI/LO registers for the MIPS datapath. Sits beside the single-cycle ALU.
- Takes the 5-bit ALU control code, plus new DIV/DIVU/MTHI/MTLO codes, through a start/busy/done handshake.
- Generalises the single-cycle multiply paths to any operand width. Adds accumulate, divide and divide-by-zero reporting.

Parameters:
- WIDTH, 32, operand/HI/LO width (even, >=4)
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
- Clk  in  1  clock, rising edge
- Rst  in  1  asynchronous, active-high reset
- Start  in  1  request; sampled only in IDLE
- Op  in  5  operation code: MULT=00011, MULTU=00100, MUL=10011, MADD=10100, MSUB=10101, DIV=11000, DIVU=11001, MTHI=11010, MTLO=11011
- A  in  WIDTH  operand rs
- B  in  WIDTH  operand rt
- Busy  out  1  operation in progress
- Done  out  1  one-cycle completion pulse
- DivZero  out  1  valid with Done; 1 = DIV/DIVU with B==0
- Hi  out  WIDTH  HI register
- Lo  out  WIDTH  LO register
- Result  out  WIDTH  low WIDTH bits of last MUL product

Behaviour:
- Reset: state IDLE; Busy, Done, DivZero = 0; Hi, Lo, Result = 0; counter = 0. Reset mid-operation aborts it; no partial HI/LO write.
- A, B and Op are captured at acceptance; later changes to them are ignored.
- States:
  - IDLE: Start=1 with a legal Op is accepted. Start with an illegal Op is ignored: no state change, no Done.
  - RUN: exactly WIDTH cycles, one radix-2 iteration per cycle.
  - FINISH: one cycle; applies signs, accumulates, writes HI/LO/Result.
  - Then IDLE with Done=1.
- Timing for an iterative op (MULT/MULTU/MUL/MADD/MSUB/DIV/DIVU) with Start sampled in cycle N:
  - Busy=1 in cycles N+1..N+WIDTH+1.
  - Done=1 only in cycle N+WIDTH+2; new Hi/Lo/Result visible from that cycle.
- Single-cycle ops, Start in cycle N; Busy never asserts; Done=1 in cycle N+1:
  - MTHI: Hi=A, Lo unchanged.
  - MTLO: Lo=A, Hi unchanged.
  - DIV/DIVU with B==0: DivZero=1 with Done; Hi/Lo unchanged; no RUN.
- Start while Busy is ignored. Start in the Done cycle is accepted (state is IDLE).
- Multiply: unsigned shift-add on operand magnitudes over a 2*WIDTH product.
  - Signed ops (MULT, MUL, MADD, MSUB) take two's-complement magnitudes at capture and negate the product in FINISH if the signs differ.
  - MULT/MULTU: {Hi,Lo} = product.
  - MADD: {Hi,Lo} = {Hi,Lo} + product, modulo 2^(2*WIDTH).
  - MSUB: {Hi,Lo} = {Hi,Lo} - product, modulo 2^(2*WIDTH).
  - MUL: Result = product[WIDTH-1:0]; Hi/Lo unchanged.
- Divide: restoring shift-subtract on magnitudes over WIDTH iterations.
  - Lo = quotient, truncated toward zero.
  - Hi = remainder, carrying the sign of the dividend.
  - DIVU treats operands as unsigned.
  - Signed overflow (A = -2^(WIDTH-1), B = -1): Lo = 2^(WIDTH-1) bit pattern, Hi = 0; no flag.
- DivZero: cleared on every new acceptance; holds its value until then.

Test Plan (WIDTH=32):
- Reset, then MULT A=FFFFFFFD (-3), B=00000007, Start in cycle N:
  - Busy high N+1..N+33.
  - Done only in N+34.
  - Hi=FFFFFFFF, Lo=FFFFFFEB.
- MULTU with A=B=FFFFFFFF -> Hi=FFFFFFFE, Lo=00000001.
- Accumulate sequence:
  - MTLO A=0000000A; MTHI A=0 -> each gives Done one cycle after Start; Busy stays low.
  - MADD A=FFFFFFFE, B=3 -> Hi=0, Lo=00000004.
  - MSUB A=1, B=5 -> Hi=FFFFFFFF, Lo=FFFFFFFF.
- Divide cases:
  - DIV A=FFFFFFF9 (-7), B=2 -> Lo=FFFFFFFD, Hi=FFFFFFFF.
  - DIV A=80000000, B=FFFFFFFF -> Lo=80000000, Hi=0.
  - DIVU A=0000000A, B=0 -> Done in N+1, DivZero=1, Hi/Lo unchanged.
- MUL A=00010000, B=00010000 -> Result=00000000, Hi/Lo unchanged. A second Start pulsed during Busy is ignored: exactly one Done.
- Start MULTU, assert Rst in cycle N+10:
  - All outputs 0 immediately (asynchronous).
  - No Done follows.
  - Next Start after Rst release completes normally.
